// File: rtl/dbg_pkg.sv
// Shared constants for the register-dump debug path: FSM encodings, frame header and frame sizing.
package dbg_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HALT = 3'd1;
    localparam logic [2:0] HDR  = 3'd2;
    localparam logic [2:0] LOAD = 3'd3;
    localparam logic [2:0] SEND = 3'd4;
    localparam logic [2:0] CHK  = 3'd5;

    localparam logic [7:0] DUMP_HEADER = 8'hA5;

    localparam int unsigned DEF_NUM_REGS = 32;
    localparam int unsigned DEF_DATA_W   = 32;

    // Header + data bytes + checksum.
    function automatic int unsigned frame_bytes(input int unsigned num_regs, input int unsigned data_w);
        return 2 + num_regs * data_w / 8;
    endfunction

    localparam int unsigned FRAME_BYTES = frame_bytes(DEF_NUM_REGS, DEF_DATA_W);

endpackage

// File: rtl/reg_dump_mux.sv
// 32:1 word mux selecting one ID-stage register for the dump sequencer.
module reg_dump_mux #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] register_0_id_out,
    input  logic [DATA_W-1:0] register_1_id_out,
    input  logic [DATA_W-1:0] register_2_id_out,
    input  logic [DATA_W-1:0] register_3_id_out,
    input  logic [DATA_W-1:0] register_4_id_out,
    input  logic [DATA_W-1:0] register_5_id_out,
    input  logic [DATA_W-1:0] register_6_id_out,
    input  logic [DATA_W-1:0] register_7_id_out,
    input  logic [DATA_W-1:0] register_8_id_out,
    input  logic [DATA_W-1:0] register_9_id_out,
    input  logic [DATA_W-1:0] register_10_id_out,
    input  logic [DATA_W-1:0] register_11_id_out,
    input  logic [DATA_W-1:0] register_12_id_out,
    input  logic [DATA_W-1:0] register_13_id_out,
    input  logic [DATA_W-1:0] register_14_id_out,
    input  logic [DATA_W-1:0] register_15_id_out,
    input  logic [DATA_W-1:0] register_16_id_out,
    input  logic [DATA_W-1:0] register_17_id_out,
    input  logic [DATA_W-1:0] register_18_id_out,
    input  logic [DATA_W-1:0] register_19_id_out,
    input  logic [DATA_W-1:0] register_20_id_out,
    input  logic [DATA_W-1:0] register_21_id_out,
    input  logic [DATA_W-1:0] register_22_id_out,
    input  logic [DATA_W-1:0] register_23_id_out,
    input  logic [DATA_W-1:0] register_24_id_out,
    input  logic [DATA_W-1:0] register_25_id_out,
    input  logic [DATA_W-1:0] register_26_id_out,
    input  logic [DATA_W-1:0] register_27_id_out,
    input  logic [DATA_W-1:0] register_28_id_out,
    input  logic [DATA_W-1:0] register_29_id_out,
    input  logic [DATA_W-1:0] register_30_id_out,
    input  logic [DATA_W-1:0] register_31_id_out,
    input  logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            5'd0:  rd_data = register_0_id_out;
            5'd1:  rd_data = register_1_id_out;
            5'd2:  rd_data = register_2_id_out;
            5'd3:  rd_data = register_3_id_out;
            5'd4:  rd_data = register_4_id_out;
            5'd5:  rd_data = register_5_id_out;
            5'd6:  rd_data = register_6_id_out;
            5'd7:  rd_data = register_7_id_out;
            5'd8:  rd_data = register_8_id_out;
            5'd9:  rd_data = register_9_id_out;
            5'd10: rd_data = register_10_id_out;
            5'd11: rd_data = register_11_id_out;
            5'd12: rd_data = register_12_id_out;
            5'd13: rd_data = register_13_id_out;
            5'd14: rd_data = register_14_id_out;
            5'd15: rd_data = register_15_id_out;
            5'd16: rd_data = register_16_id_out;
            5'd17: rd_data = register_17_id_out;
            5'd18: rd_data = register_18_id_out;
            5'd19: rd_data = register_19_id_out;
            5'd20: rd_data = register_20_id_out;
            5'd21: rd_data = register_21_id_out;
            5'd22: rd_data = register_22_id_out;
            5'd23: rd_data = register_23_id_out;
            5'd24: rd_data = register_24_id_out;
            5'd25: rd_data = register_25_id_out;
            5'd26: rd_data = register_26_id_out;
            5'd27: rd_data = register_27_id_out;
            5'd28: rd_data = register_28_id_out;
            5'd29: rd_data = register_29_id_out;
            5'd30: rd_data = register_30_id_out;
            default: rd_data = register_31_id_out;
        endcase
    end

endmodule

// File: rtl/register_dump_scheduler.sv
// Halts the pipeline, walks the register file through rd_addr and streams a framed,
// XOR-checksummed dump over the UART TX byte channel.
module register_dump_scheduler
    import dbg_pkg::*;
#(
    parameter int unsigned NUM_REGS    = DEF_NUM_REGS,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter logic [7:0]  HEADER_BYTE = DUMP_HEADER
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dump_req,
    output logic              pipe_halt,
    input  logic              pipe_idle,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       BPW       = DATA_W / 8;
    localparam int unsigned       CNT_W     = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BPW - 1);

    logic [2:0]        state, state_nxt;
    logic              pipe_halt_nxt, tx_valid_nxt, busy_nxt, done_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic [7:0]        tx_data_nxt, chk, chk_nxt, chk_upd;
    logic [DATA_W-1:0] shift, shift_nxt, shift_adv;
    logic [CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
    logic              xfer;

    assign xfer      = tx_valid & tx_ready;
    assign chk_upd   = chk ^ tx_data;
    assign shift_adv = shift << 8;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pipe_halt <= 1'b0;
            rd_addr   <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            chk       <= '0;
            shift     <= '0;
            byte_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            pipe_halt <= pipe_halt_nxt;
            rd_addr   <= rd_addr_nxt;
            tx_data   <= tx_data_nxt;
            tx_valid  <= tx_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            chk       <= chk_nxt;
            shift     <= shift_nxt;
            byte_cnt  <= byte_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pipe_halt_nxt = pipe_halt;
        rd_addr_nxt   = rd_addr;
        tx_data_nxt   = tx_data;
        tx_valid_nxt  = tx_valid;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        chk_nxt       = chk;
        shift_nxt     = shift;
        byte_cnt_nxt  = byte_cnt;

        case (state)
            IDLE: begin
                if (dump_req) begin
                    pipe_halt_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                    rd_addr_nxt   = '0;
                    chk_nxt       = '0;
                    state_nxt     = HALT;
                end
            end
            HALT: begin
                if (pipe_idle) begin
                    tx_data_nxt  = HEADER_BYTE;
                    tx_valid_nxt = 1'b1;
                    state_nxt    = HDR;
                end
            end
            HDR: begin
                if (xfer) begin
                    tx_valid_nxt = 1'b0;
                    state_nxt    = LOAD;
                end
            end
            // rd_addr was registered at least one cycle ago, so rd_data has settled.
            LOAD: begin
                shift_nxt    = rd_data;
                byte_cnt_nxt = '0;
                tx_data_nxt  = rd_data[DATA_W-1 -: 8];
                tx_valid_nxt = 1'b1;
                state_nxt    = SEND;
            end
            SEND: begin
                if (xfer) begin
                    chk_nxt      = chk_upd;
                    shift_nxt    = shift_adv;
                    byte_cnt_nxt = byte_cnt + CNT_W'(1);
                    if (byte_cnt == LAST_BYTE) begin
                        if (rd_addr != LAST_ADDR) begin
                            rd_addr_nxt  = rd_addr + ADDR_W'(1);
                            tx_valid_nxt = 1'b0;
                            state_nxt    = LOAD;
                        end else begin
                            tx_data_nxt = chk_upd;
                            state_nxt   = CHK;
                        end
                    end else begin
                        tx_data_nxt = shift_adv[DATA_W-1 -: 8];
                    end
                end
            end
            CHK: begin
                if (xfer) begin
                    tx_valid_nxt  = 1'b0;
                    pipe_halt_nxt = 1'b0;
                    done_nxt      = 1'b1;
                    busy_nxt      = 1'b0;
                    rd_addr_nxt   = '0;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_register_dump_scheduler.sv
// Directed bench for register_dump_scheduler driving it through the reg_dump_mux word path.
module tb_register_dump_scheduler;
    import dbg_pkg::*;

    logic        clock;
    logic        reset;
    logic        dump_req;
    logic        pipe_halt;
    logic        pipe_idle;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  xfer_q[$];
    logic [7:0]  exp_q[$];
    int          done_cnt = 0;
    bit          stall_pend = 0;
    logic [7:0]  stall_data = '0;

    register_dump_scheduler dut (
        .clock(clock), .reset(reset), .dump_req(dump_req), .pipe_halt(pipe_halt),
        .pipe_idle(pipe_idle), .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    reg_dump_mux #(.DATA_W(32)) mux (
        .register_0_id_out(regs[0]),   .register_1_id_out(regs[1]),
        .register_2_id_out(regs[2]),   .register_3_id_out(regs[3]),
        .register_4_id_out(regs[4]),   .register_5_id_out(regs[5]),
        .register_6_id_out(regs[6]),   .register_7_id_out(regs[7]),
        .register_8_id_out(regs[8]),   .register_9_id_out(regs[9]),
        .register_10_id_out(regs[10]), .register_11_id_out(regs[11]),
        .register_12_id_out(regs[12]), .register_13_id_out(regs[13]),
        .register_14_id_out(regs[14]), .register_15_id_out(regs[15]),
        .register_16_id_out(regs[16]), .register_17_id_out(regs[17]),
        .register_18_id_out(regs[18]), .register_19_id_out(regs[19]),
        .register_20_id_out(regs[20]), .register_21_id_out(regs[21]),
        .register_22_id_out(regs[22]), .register_23_id_out(regs[23]),
        .register_24_id_out(regs[24]), .register_25_id_out(regs[25]),
        .register_26_id_out(regs[26]), .register_27_id_out(regs[27]),
        .register_28_id_out(regs[28]), .register_29_id_out(regs[29]),
        .register_30_id_out(regs[30]), .register_31_id_out(regs[31]),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Records every accepted byte and checks that a stalled byte is held unchanged.
    always @(posedge clock) begin
        if (reset) begin
            stall_pend = 0;
        end else begin
            if (stall_pend) begin
                check("stall_valid_held", 32'(tx_valid), 32'd1);
                check("stall_data_held", 32'(tx_data), 32'(stall_data));
            end
            if (tx_valid && tx_ready) xfer_q.push_back(tx_data);
            stall_pend = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (done) done_cnt++;
        end
    end

    task automatic build_expected();
        logic [7:0]  c;
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        c = 8'h00;
        for (int r = 0; r < 32; r++) begin
            w = regs[r];
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(w[8*b +: 8]);
                c = c ^ w[8*b +: 8];
            end
        end
        exp_q.push_back(c);
    endtask

    task automatic compare_frame(input string tag);
        int n;
        check({tag, "_len"}, 32'(xfer_q.size()), 32'(FRAME_BYTES));
        n = (xfer_q.size() < exp_q.size()) ? xfer_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(xfer_q[i]), 32'(exp_q[i]));
    endtask

    task automatic start_frame();
        xfer_q.delete();
        done_cnt = 0;
        dump_req = 1'b1;
        @(posedge clock); #1;
        dump_req = 1'b0;
        check("start_halt", 32'(pipe_halt), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_addr", 32'(rd_addr), 32'd0);
    endtask

    task automatic wait_frame(input bit rnd, input int req_at, output int cycles);
        bit got  = 0;
        bit sent = 0;
        cycles = 0;
        while (!got && cycles < 3000) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            if (req_at >= 0 && !sent && xfer_q.size() >= req_at) begin
                dump_req = 1'b1;
                sent = 1;
            end else begin
                dump_req = 1'b0;
            end
            @(posedge clock); cycles++; #1;
            if (done === 1'b1) got = 1;
        end
        dump_req = 1'b0;
        tx_ready = 1'b1;
        check("frame_completes", 32'(got), 32'd1);
        check("done_halt_released", 32'(pipe_halt), 32'd0);
        check("done_busy_clear", 32'(busy), 32'd0);
        check("done_valid_clear", 32'(tx_valid), 32'd0);
        @(posedge clock); #1;
        check("done_single_cycle", 32'(done), 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int  cyc;
        bit  halt_ok;
        bit  valid_seen;
        int  qsz;

        reset = 1'b1; dump_req = 1'b0; pipe_idle = 1'b1; tx_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * 32'(i);
        repeat (3) @(posedge clock);
        #1;
        check("rst_halt", 32'(pipe_halt), 32'd0);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(rd_addr), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // 1: basic frame with a free-running transmitter
        build_expected();
        start_frame();
        wait_frame(0, -1, cyc);
        compare_frame("t1");
        if (xfer_q.size() == FRAME_BYTES) begin
            check("t1_hdr", 32'(xfer_q[0]), 32'hA5);
            check("t1_r0", {xfer_q[1], xfer_q[2], xfer_q[3], xfer_q[4]}, 32'h0000_0000);
            check("t1_r1", {xfer_q[5], xfer_q[6], xfer_q[7], xfer_q[8]}, 32'h0101_0101);
            check("t1_chk", 32'(xfer_q[129]), 32'h00);
        end

        // 2: pipeline not drained for 20 cycles, then drops idle again mid-frame
        pipe_idle = 1'b0;
        start_frame();
        halt_ok = 1; valid_seen = 0;
        repeat (20) begin
            @(posedge clock); #1;
            halt_ok    = halt_ok & pipe_halt;
            valid_seen = valid_seen | tx_valid;
        end
        check("t2_halt_held", 32'(halt_ok), 32'd1);
        check("t2_no_valid", 32'(valid_seen), 32'd0);
        pipe_idle = 1'b1;
        @(posedge clock); #1;
        check("t2_hdr_valid", 32'(tx_valid), 32'd1);
        check("t2_hdr_data", 32'(tx_data), 32'hA5);
        pipe_idle = 1'b0;
        wait_frame(0, -1, cyc);
        pipe_idle = 1'b1;
        compare_frame("t2");

        // 3: random backpressure, r5 = DEADBEEF
        regs[5] = 32'hDEAD_BEEF;
        build_expected();
        start_frame();
        wait_frame(1, -1, cyc);
        compare_frame("t3");
        if (xfer_q.size() == FRAME_BYTES) begin
            check("t3_r5", {xfer_q[21], xfer_q[22], xfer_q[23], xfer_q[24]}, 32'hDEAD_BEEF);
            check("t3_chk", 32'(xfer_q[129]), 32'h22);
        end

        // 4: second request at byte 40 is ignored
        start_frame();
        wait_frame(0, 40, cyc);
        repeat (10) @(posedge clock);
        #1;
        check("t4_busy_idle", 32'(busy), 32'd0);
        check("t4_one_frame", 32'(xfer_q.size()), 32'(FRAME_BYTES));
        check("t4_one_done", 32'(done_cnt), 32'd1);
        compare_frame("t4");

        // 5: reset while r17 is being sent
        start_frame();
        cyc = 0;
        while (!(rd_addr == 5'd17 && tx_valid) && cyc < 1000) begin
            @(posedge clock); #1; cyc++;
        end
        check("t5_reached_r17", 32'(rd_addr), 32'd17);
        reset = 1'b1;
        @(posedge clock); #1;
        check("t5_halt", 32'(pipe_halt), 32'd0);
        check("t5_valid", 32'(tx_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_addr", 32'(rd_addr), 32'd0);
        reset = 1'b0;
        qsz = xfer_q.size();
        valid_seen = 0;
        repeat (5) begin
            @(posedge clock); #1;
            valid_seen = valid_seen | tx_valid;
        end
        check("t5_no_tail", 32'(valid_seen), 32'd0);
        check("t5_no_bytes", 32'(xfer_q.size()), 32'(qsz));
        start_frame();
        wait_frame(0, -1, cyc);
        compare_frame("t5");

        // 6: all ones, timing, and a request coincident with the checksum transfer
        for (int i = 0; i < 32; i++) regs[i] = 32'hFFFF_FFFF;
        build_expected();
        start_frame();
        wait_frame(0, 129, cyc);
        check("t6_cycles", 32'(cyc), 32'd163);
        compare_frame("t6");
        if (xfer_q.size() == FRAME_BYTES)
            check("t6_chk", 32'(xfer_q[129]), 32'h00);
        valid_seen = 0;
        halt_ok = 0;
        repeat (10) begin
            @(posedge clock); #1;
            valid_seen = valid_seen | tx_valid;
            halt_ok    = halt_ok | busy | pipe_halt;
        end
        check("t6_req_at_chk_ignored", 32'(halt_ok), 32'd0);
        check("t6_no_new_frame", 32'(valid_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
